// File: rtl/ask2_modulator.sv
// ---------------------------------------------------------------------------
// ask2_modulator
// On/off keyed (2ASK) modulator. Each data bit accepted over a valid/ready
// handshake is held for SAMPLES_PER_BIT carrier samples. During that time the
// Q1.15 carrier is scaled by AMP_ONE or AMP_ZERO. A one-entry pending buffer
// lets the next bit be accepted while the current one is still on air, so
// consecutive bits go out with no gap.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   synchronous active-low reset
//   enable      in   run enable; low flushes the block to IDLE
//   carrier_i   in   [15:0] signed Q1.15 carrier sample, new one every clock
//   bit_i       in   data bit
//   bit_valid   in   bit_i is valid
//   bit_ready   out  bit_i is accepted this cycle (bit_valid && bit_ready)
//   mod_o       out  [15:0] registered signed Q1.15 modulated sample
//   mod_valid   out  mod_o carries a modulated sample
//   bit_strobe  out  pulse with the first mod_o sample of each bit
//   underrun    out  pulse one cycle after the last sample of a bit that
//                    had no successor
// ---------------------------------------------------------------------------
module ask2_modulator #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          BIT_RATE = 100_000,
  parameter logic [15:0] AMP_ONE  = 16'h7FFF,
  parameter logic [15:0] AMP_ZERO = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic [15:0] carrier_i,
  input  logic        bit_i,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [15:0] mod_o,
  output logic        mod_valid,
  output logic        bit_strobe,
  output logic        underrun
);

  localparam int SAMPLES_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int CW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Signed Q1.15 x Q1.15 product, keeping bits [30:15]. The arithmetic shift
  // truncates toward minus infinity; amp never equals 16'h8000, so bit 31 is
  // a pure sign copy and no saturation is required.
  function automatic logic [15:0] scale_q15(input logic [15:0] car,
                                            input logic [15:0] amp);
    logic signed [31:0] car_x;
    logic signed [31:0] amp_x;
    logic signed [31:0] prod;
    car_x = {{16{car[15]}}, car};
    amp_x = {{16{amp[15]}}, amp};
    prod  = car_x * amp_x;
    return 16'(prod >>> 15);
  endfunction

  logic [0:0]    state_r, state_n_s;
  logic [CW-1:0] cnt_r, cnt_n_s;
  logic          cur_bit_r, cur_bit_n_s;
  logic          pend_bit_r, pend_bit_n_s;
  logic          pend_full_r, pend_full_n_s;
  logic          und_n_s;
  logic          und_stage_r;
  logic          xfer_s;
  logic          last_s;
  logic          run_s;
  logic [15:0]   amp_s;

  // Ready is held low during reset so nothing is taken before the state
  // registers have been initialised.
  assign bit_ready = sys_rst_n & enable & ~pend_full_r;
  assign xfer_s    = bit_valid & bit_ready;
  assign last_s    = (cnt_r == CNT_LAST);
  assign run_s     = enable & (state_r == ST_RUN);
  assign amp_s     = cur_bit_r ? AMP_ONE : AMP_ZERO;

  // Next-state logic: bit sequencing, pending buffer and underrun detection.
  always_comb begin
    state_n_s     = state_r;
    cnt_n_s       = cnt_r;
    cur_bit_n_s   = cur_bit_r;
    pend_bit_n_s  = pend_bit_r;
    pend_full_n_s = pend_full_r;
    und_n_s       = 1'b0;
    if (!enable) begin
      state_n_s     = ST_IDLE;
      cnt_n_s       = CNT_ZERO;
      pend_full_n_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_n_s       = CNT_ZERO;
          pend_full_n_s = 1'b0;
          if (xfer_s) begin
            cur_bit_n_s = bit_i;
            state_n_s   = ST_RUN;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (last_s) begin
            cnt_n_s = CNT_ZERO;
            if (pend_full_r) begin
              cur_bit_n_s   = pend_bit_r;
              pend_full_n_s = 1'b0;
            end else if (xfer_s) begin
              // Bit arriving exactly on the boundary skips the buffer.
              cur_bit_n_s = bit_i;
            end else begin
              und_n_s   = 1'b1;
              state_n_s = ST_IDLE;
            end
          end else begin
            cnt_n_s = cnt_r + CW'(1'b1);
            if (xfer_s) begin
              pend_bit_n_s  = bit_i;
              pend_full_n_s = 1'b1;
            end else begin
              pend_full_n_s = pend_full_r;
            end
          end
        end
        default: begin
          state_n_s     = ST_IDLE;
          cnt_n_s       = CNT_ZERO;
          pend_full_n_s = 1'b0;
        end
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      cur_bit_r   <= 1'b0;
      pend_bit_r  <= 1'b0;
      pend_full_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      cnt_r       <= cnt_n_s;
      cur_bit_r   <= cur_bit_n_s;
      pend_bit_r  <= pend_bit_n_s;
      pend_full_r <= pend_full_n_s;
    end
  end

  // Output registers. underrun is delayed one extra stage so it lines up
  // with the first idle output cycle instead of the last sample; dropping
  // enable suppresses a pending report.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      mod_o       <= 16'h0000;
      mod_valid   <= 1'b0;
      bit_strobe  <= 1'b0;
      und_stage_r <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      mod_o       <= run_s ? scale_q15(carrier_i, amp_s) : 16'h0000;
      mod_valid   <= run_s;
      bit_strobe  <= run_s & (cnt_r == CNT_ZERO);
      und_stage_r <= und_n_s;
      underrun    <= und_stage_r & enable;
    end
  end

endmodule
